// File: rtl/easyaxi_slv_rd_pkg.sv
// Shared AXI width/encoding macros plus the types used by the EasyAXI read slave.
// The optional range check is enabled with EASYAXI_SLV_RD_DECERR_EN (see easyaxi_slv_rd).
`ifndef EASYAXI_DEFINE_SV
`define EASYAXI_DEFINE_SV
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_SIZE_1B     3'b000
`define AXI_SIZE_2B     3'b001
`define AXI_SIZE_4B     3'b010
`define AXI_SIZE_8B     3'b011
`define AXI_SIZE_16B    3'b100
`define AXI_SIZE_32B    3'b101
`define AXI_SIZE_64B    3'b110
`define AXI_SIZE_128B   3'b111
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_slv_rd_pkg;

    localparam int ID_W    = `AXI_ID_W;
    localparam int ADDR_W  = `AXI_ADDR_W;
    localparam int LEN_W   = `AXI_LEN_W;
    localparam int SIZE_W  = `AXI_SIZE_W;
    localparam int BURST_W = `AXI_BURST_W;
    localparam int DATA_W  = `AXI_DATA_W;
    localparam int RESP_W  = `AXI_RESP_W;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

    // Beat data is the beat address aligned down to the transfer size.
    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] addr,
                                                    input logic [SIZE_W-1:0] size);
        logic [ADDR_W-1:0] aligned;
        aligned = addr & ~((ADDR_W'(1) << size) - ADDR_W'(1));
        return DATA_W'(aligned);
    endfunction

endpackage

// File: rtl/easyaxi_burst_addr.sv
// Combinational AXI beat-address stepper: next address for FIXED/INCR/WRAP plus an
// illegal-burst flag. Shared by the EasyAXI read and write slaves.
module easyaxi_burst_addr
    import easyaxi_slv_rd_pkg::*;
(
    input  logic [ADDR_W-1:0]  cur_addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [SIZE_W-1:0]  size_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic [ADDR_W-1:0]  next_addr_o,
    output logic               illegal_o
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_len_ok;
    logic              reserved;
    logic              oversize;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        incr        = ADDR_W'(1) << size_i;
        incr_addr   = cur_addr_i + incr;
        wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) * incr) - ADDR_W'(1);
        wrap_len_ok = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
        reserved    = (burst_i == 2'b11);
        oversize    = (size_i > SIZE_W'(MAX_SIZE));
        illegal_o   = reserved | oversize | ((burst_i == `AXI_BURST_WRAP) & ~wrap_len_ok);
        next_addr_o = incr_addr;
        case (burst_i)
            `AXI_BURST_FIXED: next_addr_o = cur_addr_i;
            `AXI_BURST_WRAP: begin
                // Malformed WRAP lengths fall back to INCR stepping.
                if (wrap_len_ok) begin
                    next_addr_o = (cur_addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read slave: queues AR requests and returns in-order bursts whose data is the beat address.
// Define EASYAXI_SLV_RD_DECERR_EN to return DECERR/zero data for beats at or above MEM_SIZE.
module easyaxi_slv_rd
    import easyaxi_slv_rd_pkg::*;
#(
    parameter int                OST_DEPTH = 4,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = 'h100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axi_slv_arvalid,
    output logic               axi_slv_arready,
    input  logic [ID_W-1:0]    axi_slv_arid,
    input  logic [ADDR_W-1:0]  axi_slv_araddr,
    input  logic [LEN_W-1:0]   axi_slv_arlen,
    input  logic [SIZE_W-1:0]  axi_slv_arsize,
    input  logic [BURST_W-1:0] axi_slv_arburst,
    output logic               axi_slv_rvalid,
    input  logic               axi_slv_rready,
    output logic [ID_W-1:0]    axi_slv_rid,
    output logic [DATA_W-1:0]  axi_slv_rdata,
    output logic [RESP_W-1:0]  axi_slv_rresp,
    output logic               axi_slv_rlast,
    output logic               idle
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ar_req_t           fifo_q [OST_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, avail_q;
    state_e            state_q, state_d;
    ar_req_t           cur_q, cur_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [RESP_W-1:0] rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic              push, pop;
    ar_req_t           ar_in, head, ba_req;
    logic [ADDR_W-1:0] next_addr, beat_addr;
    logic              illegal, beat_err;
    logic [DATA_W-1:0] beat_rdata;
    logic [RESP_W-1:0] beat_rresp;

    assign ar_in   = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                       size: axi_slv_arsize, burst: axi_slv_arburst};
    assign head    = fifo_q[rd_ptr_q];
    assign push    = axi_slv_arvalid & ~full_q;
    // avail_q lags the count by one cycle, giving the two-cycle AR-to-R latency.
    assign pop     = (state_q == ST_IDLE) & avail_q & (count_q != '0);
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // In IDLE the stepper evaluates the head entry (legality at pop); in BURST the live beat.
    assign ba_req  = (state_q == ST_IDLE) ? head : cur_q;

    easyaxi_burst_addr u_burst_addr (
        .cur_addr_i  (ba_req.addr),
        .len_i       (ba_req.len),
        .size_i      (ba_req.size),
        .burst_i     (ba_req.burst),
        .next_addr_o (next_addr),
        .illegal_o   (illegal)
    );

    always_comb begin
        beat_addr  = (state_q == ST_IDLE) ? head.addr : next_addr;
        beat_err   = (state_q == ST_IDLE) ? illegal : err_q;
        beat_rdata = beat_data(beat_addr, ba_req.size);
        beat_rresp = beat_err ? `AXI_RESP_SLVERR : `AXI_RESP_OKAY;
`ifdef EASYAXI_SLV_RD_DECERR_EN
        if (beat_addr >= MEM_SIZE) begin
            beat_rresp = `AXI_RESP_DECERR;
            beat_rdata = '0;
        end
`endif
    end

`ifndef EASYAXI_SLV_RD_DECERR_EN
    logic unused_mem_size;
    assign unused_mem_size = ^MEM_SIZE;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d    = ST_BURST;
                    cur_d      = head;
                    beat_cnt_d = '0;
                    err_d      = illegal;
                    rdata_d    = beat_rdata;
                    rresp_d    = beat_rresp;
                    rlast_d    = (head.len == '0);
                end
            end
            ST_BURST: begin
                if (axi_slv_rready) begin
                    if (beat_cnt_q == cur_q.len) begin
                        state_d = ST_IDLE;
                        rlast_d = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                        cur_d.addr = next_addr;
                        rdata_d    = beat_rdata;
                        rresp_d    = beat_rresp;
                        rlast_d    = ((beat_cnt_q + LEN_W'(1)) == cur_q.len);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: queue storage has no reset; count_q alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= ar_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            avail_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= `AXI_RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(OST_DEPTH));
            avail_q    <= (count_q != '0);
            state_q    <= state_d;
            cur_q      <= cur_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign axi_slv_arready = ~full_q;
    assign axi_slv_rvalid  = (state_q == ST_BURST);
    assign axi_slv_rid     = cur_q.id;
    assign axi_slv_rdata   = rdata_q;
    assign axi_slv_rresp   = rresp_q;
    assign axi_slv_rlast   = rlast_q;
    assign idle            = (state_q == ST_IDLE) && (count_q == '0);

endmodule

// File: doc/easyaxi_slv_rd.md
Name: easyaxi_slv_rd

Overview:
AXI read slave that terminates the master's AR/R channels.
- Queues up to OST_DEPTH accepted AR requests in a FIFO.
- Serves them strictly in order as bursts on R, with FIXED/INCR/WRAP beat-address generation.
- Returns deterministic data (the beat address), so the master's data, ID and resp checks are self-checking.
- Sits directly downstream of the read master in the EasyAXI testbench.

Parameters:
OST_DEPTH, 4, AR queue depth (power of 2, >=2)
MEM_SIZE, 'h100, byte size of decoded region (used only with EASYAXI_SLV_RD_DECERR_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
axi_slv_arvalid  in  1  AR valid
axi_slv_arready  out  1  AR ready
axi_slv_arid  in  `AXI_ID_W  AR ID
axi_slv_araddr  in  `AXI_ADDR_W  start byte address
axi_slv_arlen  in  `AXI_LEN_W  beats-1
axi_slv_arsize  in  `AXI_SIZE_W  log2 bytes/beat
axi_slv_arburst  in  `AXI_BURST_W  FIXED/INCR/WRAP
axi_slv_rvalid  out  1  R valid
axi_slv_rready  in  1  R ready
axi_slv_rid  out  `AXI_ID_W  ID of the burst being served
axi_slv_rdata  out  `AXI_DATA_W  beat data
axi_slv_rresp  out  `AXI_RESP_W  beat response
axi_slv_rlast  out  1  final beat of the burst
idle  out  1  queue empty and FSM in IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - Queue emptied, FSM to IDLE, beat counter 0.
  - Outputs: arready=1, rvalid=0, rlast=0, rid=0, rdata=0, rresp=OKAY, idle=1.
  - Reset mid-burst abandons the burst; rvalid is 0 in the cycle after the reset edge.
- AR accept:
  - arready = ~full (registered full flag).
  - On arvalid&arready, push {id, addr, len, size, burst}.
  - A push and a pop in the same cycle are both honoured.
  - No push occurs when full; no pop occurs when empty.
- FSM states: IDLE and BURST.
  - IDLE: if the queue is non-empty, pop the head, load cur_addr=addr and beat_cnt=0, then go to BURST.
  - BURST: rvalid=1. On rvalid&rready:
    - If beat_cnt==len: return to IDLE. Exactly one bubble cycle follows before the next burst.
    - Otherwise: beat_cnt+1 and cur_addr=next_addr.
- Latency: an AR handshake at edge N with an empty queue and FSM in IDLE gives the first rvalid after edge N+2.
- R payload:
  - Registered outputs.
  - rid, rdata, rresp and rlast are held stable while rvalid & ~rready.
  - rlast = (beat_cnt==len).
- Beat data: rdata = cur_addr with the low `arsize` bits cleared, zero-extended or truncated to `AXI_DATA_W.
- Address arithmetic (incr = 1<<size, `AXI_ADDR_W` bits, modulo 2^`AXI_ADDR_W`):
  - FIXED: next = cur_addr.
  - INCR: next = cur_addr + incr.
  - WRAP: bound = (len+1)*incr; next = (cur_addr & ~(bound-1)) | ((cur_addr+incr) & (bound-1)).
- SLVERR conditions (evaluated at pop, applied to every beat of the burst):
  - burst==2'b11 (reserved); address then advances as INCR.
  - WRAP with len not in {1,3,7,15}; address then advances as INCR.
  - (1<<size) > `AXI_DATA_W/8.
  - The burst still completes with len+1 beats.
- No 4KB-boundary check; the slave follows the address arithmetic across the boundary.

Optional Feature:
EASYAXI_SLV_RD_DECERR_EN
- Defined:
  - Any beat with cur_addr >= MEM_SIZE returns rresp=DECERR and rdata=0.
  - Evaluated per beat; DECERR takes precedence over SLVERR.
- Undefined: no range check; MEM_SIZE unused; all non-SLVERR beats are OKAY.

Decomposition:
- Shared `define include (existing AXI macro file) holds:
  - Width macros `AXI_ID_W/ADDR_W/LEN_W/SIZE_W/BURST_W/DATA_W/RESP_W.
  - Burst encodings `AXI_BURST_FIXED/INCR/WRAP.
  - Size encodings `AXI_SIZE_*.
  - Response encodings `AXI_RESP_OKAY/SLVERR/DECERR.
- One sub-module: easyaxi_burst_addr. It is purely combinational: {cur_addr, len, size, burst} -> {next_addr, illegal flag}. It is reused later by the write slave.
- The AR FIFO is inline (pointer plus count); no separate module.

Test Plan:
1. INCR: arid=1, araddr=0x10, len=3, size=4B, rready=1 -> 4 beats with rdata 0x10, 0x14, 0x18, 0x1C; rid=1; OKAY; rlast only on beat 4; first rvalid 2 cycles after the AR handshake.
2. WRAP: araddr=0x34, len=3, size=4B -> rdata 0x34, 0x38, 0x3C, 0x30. FIXED: araddr=0x30, len=3 -> rdata 0x30 ×4.
3. Outstanding: 5 back-to-back ARs (ids 0..4) with rready=0 -> 4 accepted, arready=0 on the 5th. Release rready -> bursts returned in id order 0, 1, 2, 3, 4. Arready returns 1 the cycle after the first pop.
4. Backpressure: rready toggled 1/0 per cycle during a len=7 INCR burst -> payload stable while stalled; exactly 8 handshakes; idle=1 after the final beat.
5. Errors: WRAP len=2 -> 3 beats, all SLVERR. burst=2'b11, addr=0x0, len=1 -> rdata 0x0, 0x4, both SLVERR. With EASYAXI_SLV_RD_DECERR_EN and MEM_SIZE=0x100: INCR addr=0xF8, len=3 -> OKAY, OKAY, DECERR, DECERR, with rdata 0 on the DECERR beats.
6. Reset mid-burst: assert rst on beat 2 of 4 with the queue holding 2 entries -> next cycle rvalid=0, arready=1, idle=1; a new AR is then served normally.
